// File: rtl/rng_conditioner_pkg.sv
// rtl/rng_conditioner_pkg.sv - shared constants and helpers for the rng conditioner
package rng_conditioner_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 2;

  // Address width for a power-of-two FIFO; the pointers carry one extra wrap bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rng_byte_fifo.sv
// rtl/rng_byte_fifo.sv - first-word-fall-through byte FIFO; head reads 0 when empty
module rng_byte_fifo
  import rng_conditioner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PW = ptr_w(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              do_push, do_pop;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = i_pop & ~o_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push = i_push & (~o_full | do_pop);
  assign o_data  = o_empty ? '0 : mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (PW+1)'(1);
    if (do_pop)  rd_d = rd_q + (PW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rng_conditioner.sv
// rtl/rng_conditioner.sv - von Neumann debias, LSB-first byte packing, repetition health test
module rng_conditioner
  import rng_conditioner_pkg::*;
#(
  parameter int REP_LIMIT  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [LANES-1:0]  i_raw,
  input  logic              i_raw_valid,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_drop,
  output logic              o_health_fail
);

  logic              phase_q, phase_d;
  logic [LANES-1:0]  stored_q, stored_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] buf_q, buf_d;
  logic [LANES-1:0]  last_q, last_d;
  logic [7:0]        run_q, run_d, run_next;
  logic              fail_q, fail_d;
  logic              drop_q, drop_d;
  logic              accept, trip, push, pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0] push_data;

  assign accept   = i_en & i_raw_valid & ~fail_q;
  // run_q == 0 only straight after reset, so the first sample always starts a run of 1.
  assign run_next = (run_q != 8'd0 && i_raw == last_q) ? run_q + 8'd1 : 8'd1;
  assign trip     = accept && (run_next == 8'(REP_LIMIT));
  assign pop      = o_valid & i_ready;

  always_comb begin
    phase_d   = phase_q;
    stored_d  = stored_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    last_d    = last_q;
    run_d     = run_q;
    fail_d    = fail_q;
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      last_d = i_raw;
      run_d  = run_next;
      if (trip) begin
        fail_d  = 1'b1;
        phase_d = 1'b0;
        cnt_d   = '0;
        buf_d   = '0;
      end else if (!phase_q) begin
        stored_d = i_raw;
        phase_d  = 1'b1;
      end else begin
        phase_d = 1'b0;
        // Lane 0 is inserted first so it lands in the lower bit position.
        for (int l = 0; l < LANES; l++) begin
          if (stored_q[l] != i_raw[l]) begin
            buf_d[cnt_d] = stored_q[l];
            if (cnt_d == 3'd7) begin
              push      = 1'b1;
              push_data = buf_d;
              buf_d     = '0;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_d + 3'd1;
            end
          end
        end
      end
    end
    drop_d = push & fifo_full & ~pop;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q  <= 1'b0;
      stored_q <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      last_q   <= '0;
      run_q    <= '0;
      fail_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      stored_q <= stored_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      last_q   <= last_d;
      run_q    <= run_d;
      fail_q   <= fail_d;
      drop_q   <= drop_d;
    end
  end

  rng_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (push_data),
    .i_pop   (pop),
    .o_data  (o_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_valid       = ~fifo_empty;
  assign o_drop        = drop_q;
  assign o_health_fail = fail_q;

endmodule

// File: tb/tb_rng_conditioner.sv
// tb/tb_rng_conditioner.sv - directed self-checking bench for rng_conditioner
module tb_rng_conditioner;

  logic       clk = 1'b0;
  logic       reset, en, raw_valid, ready;
  logic [1:0] raw;
  logic [7:0] data;
  logic       valid, drop, hf;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  rng_conditioner #(.REP_LIMIT(16), .FIFO_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_en          (en),
    .i_raw         (raw),
    .i_raw_valid   (raw_valid),
    .o_data        (data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_drop        (drop),
    .o_health_fail (hf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; raw_valid = 1'b0; raw = 2'b00; ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data); end
    tests++; if (drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b expected 0", drop); end
    tests++; if (hf !== 1'b0) begin fails++; $display("FAIL reset_hf: got %b expected 0", hf); end
  endtask

  task automatic test_stream();
    int pops = 0;
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      raw = (k % 2 == 1) ? 2'b10 : 2'b01;
      raw_valid = 1'b1;
      step();
      if (k == 6) begin
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL stream_early_valid: got %b expected 0", valid); end
      end
      if (k == 7) begin
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL stream_first_valid: got %b expected 1", valid); end
      end
      if (valid === 1'b1) begin
        pops++;
        tests++; if (data !== 8'h55) begin fails++; $display("FAIL stream_data: got %h expected 55", data); end
      end
    end
    raw_valid = 1'b0;
    step();
    tests++; if (pops != 2) begin fails++; $display("FAIL stream_count: got %0d expected 2", pops); end
  endtask

  task automatic test_full();
    int drops = 0;
    int pops = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      raw = (k % 2 == 1) ? 2'b10 : 2'b01;
      raw_valid = 1'b1;
      step();
      if (drop === 1'b1) drops++;
      if (k == 39) begin
        tests++; if (drop !== 1'b1) begin fails++; $display("FAIL full_drop_pulse: got %b expected 1", drop); end
      end
    end
    raw_valid = 1'b0;
    step();
    tests++; if (drop !== 1'b0) begin fails++; $display("FAIL full_drop_clear: got %b expected 0", drop); end
    tests++; if (drops != 1) begin fails++; $display("FAIL full_drop_count: got %0d expected 1", drops); end
    tests++; if (valid !== 1'b1 || data !== 8'h55) begin fails++; $display("FAIL full_head: got %b/%h expected 1/55", valid, data); end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (valid === 1'b1) begin
        pops++;
        tests++; if (data !== 8'h55) begin fails++; $display("FAIL full_pop_data: got %h expected 55", data); end
      end
      step();
    end
    tests++; if (pops != 4) begin fails++; $display("FAIL full_pop_count: got %0d expected 4", pops); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL full_empty: got %b expected 0", valid); end
  endtask

  task automatic test_health();
    logic any_valid = 1'b0;
    do_reset();
    ready = 1'b1;
    raw = 2'b11;
    raw_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      any_valid |= valid;
      if (k == 14) begin
        tests++; if (hf !== 1'b0) begin fails++; $display("FAIL health_early: got %b expected 0", hf); end
      end
      if (k == 15) begin
        tests++; if (hf !== 1'b1) begin fails++; $display("FAIL health_trip: got %b expected 1", hf); end
      end
    end
    for (int k = 0; k < 16; k++) begin
      raw = (k % 2 == 1) ? 2'b10 : 2'b01;
      step();
      any_valid |= valid;
    end
    tests++; if (hf !== 1'b1) begin fails++; $display("FAIL health_sticky: got %b expected 1", hf); end
    tests++; if (any_valid !== 1'b0) begin fails++; $display("FAIL health_no_output: got %b expected 0", any_valid); end
    do_reset();
    tests++; if (hf !== 1'b0) begin fails++; $display("FAIL health_reset: got %b expected 0", hf); end
  endtask

  task automatic test_rep_boundary();
    do_reset();
    raw_valid = 1'b1;
    raw = 2'b11;
    for (int k = 0; k < 15; k++) step();
    tests++; if (hf !== 1'b0) begin fails++; $display("FAIL rep_15_same: got %b expected 0", hf); end
    raw = 2'b00;
    for (int k = 0; k < 15; k++) step();
    tests++; if (hf !== 1'b0) begin fails++; $display("FAIL rep_restart: got %b expected 0", hf); end
    step();
    tests++; if (hf !== 1'b1) begin fails++; $display("FAIL rep_16th: got %b expected 1", hf); end
    raw_valid = 1'b0;
  endtask

  task automatic test_enable();
    int acc = 0;
    logic exp_v;
    do_reset();
    ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      en = !(cyc >= 4 && cyc <= 8);
      raw = (acc % 2 == 1) ? 2'b10 : 2'b01;
      raw_valid = 1'b1;
      step();
      if (en) acc++;
      exp_v = (cyc == 13 || cyc == 21 || cyc == 29);
      tests++; if (valid !== exp_v) begin fails++; $display("FAIL enable_valid cyc %0d: got %b expected %b", cyc, valid, exp_v); end
      if (exp_v) begin
        tests++; if (data !== 8'h55) begin fails++; $display("FAIL enable_data cyc %0d: got %h expected 55", cyc, data); end
      end
    end
    en = 1'b1;
    raw_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pops = 0;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      raw = (k % 2 == 1) ? 2'b10 : 2'b01;
      raw_valid = 1'b1;
      step();
    end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL mid_prefill: got %b expected 1", valid); end
    reset = 1'b1;
    raw_valid = 1'b0;
    step();
    reset = 1'b0;
    tests++; if (valid !== 1'b0 || data !== 8'h00 || drop !== 1'b0 || hf !== 1'b0)
      begin fails++; $display("FAIL mid_reset_outputs: got %b/%h/%b/%b expected 0/00/0/0", valid, data, drop, hf); end
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      raw = (k % 2 == 1) ? 2'b10 : 2'b01;
      raw_valid = (k < 8);
      step();
      if (valid === 1'b1) begin
        pops++;
        tests++; if (data !== 8'h55) begin fails++; $display("FAIL mid_data: got %h expected 55", data); end
      end
    end
    tests++; if (pops != 1) begin fails++; $display("FAIL mid_count: got %0d expected 1", pops); end
  endtask

  task automatic test_half_rate();
    int acc = 0;
    logic exp_v;
    do_reset();
    ready = 1'b1;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      raw_valid = (cyc % 2 == 1);
      raw = raw_valid ? ((acc % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
      step();
      if (raw_valid) acc++;
      exp_v = (cyc == 15 || cyc == 31);
      tests++; if (valid !== exp_v) begin fails++; $display("FAIL half_valid cyc %0d: got %b expected %b", cyc, valid, exp_v); end
      if (exp_v) begin
        tests++; if (data !== 8'h55) begin fails++; $display("FAIL half_data cyc %0d: got %h expected 55", cyc, data); end
      end
    end
    raw_valid = 1'b0;
  endtask

  task automatic test_odd_alignment();
    logic [1:0] seq [18] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10,
                             2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [7:0] got [4];
    int nb = 0;
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      raw_valid = (k < 18);
      raw = (k < 18) ? seq[k] : 2'b00;
      step();
      if (valid === 1'b1 && nb < 4) begin got[nb] = data; nb++; end
    end
    tests++; if (nb != 2) begin fails++; $display("FAIL odd_count: got %0d expected 2", nb); end
    if (nb >= 2) begin
      tests++; if (got[0] !== 8'h2B) begin fails++; $display("FAIL odd_byte0: got %h expected 2b", got[0]); end
      tests++; if (got[1] !== 8'hAB) begin fails++; $display("FAIL odd_byte1: got %h expected ab", got[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_health();
    test_rep_boundary();
    test_enable();
    test_reset_mid();
    test_half_rate();
    test_odd_alignment();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rng_conditioner.md
# rng_conditioner

Downstream consumer of the 2-bit raw random symbol stream produced by the randomizer core. Applies per-lane von Neumann debiasing and packs the surviving bits LSB-first into bytes. Buffers the bytes in a small first-word-fall-through FIFO drained by a valid/ready handshake. Runs a repetition-count health test on the raw symbols and latches a sticky failure that blocks output of suspect data.

## Interface
Parameters:
- REP_LIMIT, 16: consecutive identical raw symbols that trip the health test (legal range 2..255).
- FIFO_DEPTH, 4: output byte FIFO depth (power of two, ≥2).

Ports:
- i_clk  in  1  single clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  enable; low = raw input ignored, all state held.
- i_raw  in  2  raw symbol from randomizer; bit 0 = lane 0, bit 1 = lane 1.
- i_raw_valid  in  1  i_raw is a new sample this cycle.
- o_data  out  8  head-of-FIFO byte; 0 when FIFO empty.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
- o_drop  out  1  one-cycle pulse: completed byte discarded, FIFO full.
- o_health_fail  out  1  sticky repetition-test failure.

## Operation
- Sample accepted on an edge when i_en & i_raw_valid & ~o_health_fail.
- Per lane, phase bit toggles on each accepted sample.
  - Phase 0: store the bit.
  - Phase 1: compare the stored bit with the new bit.
  - Stored 1, new 0 -> emit 1.
  - Stored 0, new 1 -> emit 0.
  - 00 or 11 -> emit nothing.
- Both lanes are in the same phase at all times.
- Packer holds a 3-bit count and an 8-bit shift buffer. Emitted bits fill bit[count] upward.
  - If both lanes emit on the same edge, lane 0 takes the lower position.
  - If count=7 and both lanes emit: lane 0 completes the byte, and lane 1 becomes bit 0 of the next byte (count=1).
- A completed byte is pushed into the FIFO on the same edge.
  - If the FIFO is full and no pop occurs that edge, the byte is dropped and o_drop pulses for one cycle after.
  - Simultaneous pop and push on a full FIFO: both succeed.
- Health test, on accepted samples only:
  - Keep last symbol and run count (1..REP_LIMIT).
  - Same symbol -> count+1; different symbol -> count=1.
  - Count reaching REP_LIMIT sets o_health_fail, and clears the packer count/buffer and both lane phases.
  - FIFO contents already stored remain readable.
  - Only i_reset clears o_health_fail.
- i_en low: no sample accepted, phases, packer and run count held. FIFO pops still occur.
- Reset values:
  - o_data=0, o_valid=0, o_drop=0, o_health_fail=0.
  - FIFO empty, packer count 0, phases 0, run count 0 (first accepted sample sets it to 1).
- Reset mid-byte discards the partial byte and all FIFO contents.

## Timing
- Bits emitted on the edge accepting the phase-1 sample.
- Byte visible on o_data/o_valid the cycle after the edge that completes it, when the FIFO was empty (1-cycle latency).
- Pop on the edge where o_valid & i_ready; the next entry appears the following cycle.
- o_health_fail asserts the cycle after the REP_LIMIT-th identical accepted sample. No bit from that sample is emitted.

## Structure
- Shared package: FIFO pointer width function, byte width constant (8), lane count constant (2).
- One natural sub-module, `rng_byte_fifo`: parameterised FWFT FIFO with push/pop/full/empty.
- Debias, packer and health test stay in the top.

## Test plan
- Reset, then i_raw alternating 2'b01, 2'b10 with valid every cycle, i_ready=1 -> after 8 samples o_valid=1, o_data=8'h55; a new 8'h55 every 8 samples.
- Same stream with i_ready=0 for 40 samples -> 4 bytes of 8'h55 stored; 5th completion pulses o_drop; then i_ready=1 pops exactly 4 bytes.
- i_raw=2'b11 for 16 accepted samples (REP_LIMIT=16) -> no bytes emitted; o_health_fail rises after the 16th and stays high; further input ignored until i_reset.
- Alternating stream with i_en low for 5 cycles after sample 3 -> output identical to the uninterrupted run, delayed 5 cycles.
- i_reset asserted after 5 samples of the alternating stream -> all outputs 0 next cycle; the next 8 samples yield exactly one 8'h55.
- i_raw_valid every other cycle -> packing is unaffected; bytes arrive at half rate.
